// File: rtl/wb_commit_queue_pkg.sv
// Shared register-bus defines, entry type and lane-accept helper for the commit queue.
// WB_COMMIT_FWD_EN (optional) enables the four forwarding lookup ports.
`ifndef WB_COMMIT_QUEUE_DEFINES
`define WB_COMMIT_QUEUE_DEFINES
`define RegAddrBus  4:0
`define RegBus      31:0
`define NOPRegAddr  5'b00000
`define ZeroWord    32'h00000000
`define CommitDepth 8
`endif

package wb_commit_queue_pkg;

  typedef struct packed {
    logic [`RegAddrBus] waddr;
    logic [`RegBus]     wdata;
  } commit_entry_t;

  // Results targeting r0 carry no architectural effect and are never buffered
  function automatic logic lane_accept(input logic valid, input logic [`RegAddrBus] waddr);
    return valid && (waddr != `NOPRegAddr);
  endfunction

endpackage

// File: rtl/wb_commit_queue_if.sv
// Enqueue, drain and status signals of the write-back commit queue.
// WB_COMMIT_FWD_EN adds the fwd_raddrK/fwd_hitK/fwd_dataK lookup signals.
interface wb_commit_queue_if #(
  parameter int unsigned PTR_W = 3
);
  logic               flush;
  logic               stall;
  logic               in0_valid;
  logic [`RegAddrBus] in0_waddr;
  logic [`RegBus]     in0_wdata;
  logic               in1_valid;
  logic [`RegAddrBus] in1_waddr;
  logic [`RegBus]     in1_wdata;
  logic               in_ready;
  logic               we1;
  logic [`RegAddrBus] waddr1;
  logic [`RegBus]     wdata1;
  logic               we2;
  logic [`RegAddrBus] waddr2;
  logic [`RegBus]     wdata2;
  logic [PTR_W:0]     count;
  logic               err_ovf;
`ifdef WB_COMMIT_FWD_EN
  logic [`RegAddrBus] fwd_raddr1, fwd_raddr2, fwd_raddr3, fwd_raddr4;
  logic               fwd_hit1, fwd_hit2, fwd_hit3, fwd_hit4;
  logic [`RegBus]     fwd_data1, fwd_data2, fwd_data3, fwd_data4;
`endif

  modport master (
    output flush, stall, in0_valid, in0_waddr, in0_wdata, in1_valid, in1_waddr, in1_wdata,
    input  in_ready, we1, waddr1, wdata1, we2, waddr2, wdata2, count, err_ovf
`ifdef WB_COMMIT_FWD_EN
    ,
    output fwd_raddr1, fwd_raddr2, fwd_raddr3, fwd_raddr4,
    input  fwd_hit1, fwd_hit2, fwd_hit3, fwd_hit4, fwd_data1, fwd_data2, fwd_data3, fwd_data4
`endif
  );

  modport slave (
    input  flush, stall, in0_valid, in0_waddr, in0_wdata, in1_valid, in1_waddr, in1_wdata,
    output in_ready, we1, waddr1, wdata1, we2, waddr2, wdata2, count, err_ovf
`ifdef WB_COMMIT_FWD_EN
    ,
    input  fwd_raddr1, fwd_raddr2, fwd_raddr3, fwd_raddr4,
    output fwd_hit1, fwd_hit2, fwd_hit3, fwd_hit4, fwd_data1, fwd_data2, fwd_data3, fwd_data4
`endif
  );
endinterface

// File: rtl/wb_commit_mem.sv
// Commit-queue storage: Depth entries, two write ports, two read ports, async clear.
// WB_COMMIT_FWD_EN exposes the whole array for the forwarding search.
module wb_commit_mem
  import wb_commit_queue_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned PtrW  = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_a_i,
  input  logic [PtrW-1:0] waddr_a_i,
  input  commit_entry_t   wdata_a_i,
  input  logic            we_b_i,
  input  logic [PtrW-1:0] waddr_b_i,
  input  commit_entry_t   wdata_b_i,
  input  logic [PtrW-1:0] raddr_a_i,
  input  logic [PtrW-1:0] raddr_b_i,
  output commit_entry_t   rdata_a_o,
  output commit_entry_t   rdata_b_o
`ifdef WB_COMMIT_FWD_EN
  ,
  output commit_entry_t   mem_o [Depth]
`endif
);

  commit_entry_t mem_q [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (we_a_i) mem_q[waddr_a_i] <= wdata_a_i;
      if (we_b_i) mem_q[waddr_b_i] <= wdata_b_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

`ifdef WB_COMMIT_FWD_EN
  assign mem_o = mem_q;
`endif

endmodule

// File: rtl/wb_commit_queue.sv
// Dual-issue write-back commit queue: in-order 2-in/2-out FIFO in front of the regfile.
// WB_COMMIT_FWD_EN adds a four-port youngest-match forwarding search over buffered entries.
module wb_commit_queue
  import wb_commit_queue_pkg::*;
#(
  parameter int unsigned DEPTH = `CommitDepth,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  wb_commit_queue_if.slave bus
);

  localparam logic [PTR_W:0]   MaxFill = (PTR_W+1)'(DEPTH - 2);
  localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head_nxt, tail_nxt;
  logic [PTR_W:0]   count_q, count_d, n_push, n_pop;
  logic             err_ovf_q, err_ovf_d;
  logic             acc0, acc1, in_ready, push, we1, we2, has1, has2;
  commit_entry_t    wr_a, wr_b, rd_a, rd_b;

  assign acc0     = lane_accept(bus.in0_valid, bus.in0_waddr);
  assign acc1     = lane_accept(bus.in1_valid, bus.in1_waddr);
  assign in_ready = (count_q <= MaxFill);
  assign push     = in_ready && !bus.flush;
  assign has1     = |count_q;
  assign has2     = |count_q[PTR_W:1];
  assign we1      = has1 && !bus.stall && !bus.flush;
  assign we2      = has2 && !bus.stall && !bus.flush;
  assign head_nxt = head_q + PtrOne;
  assign tail_nxt = tail_q + PtrOne;

  // Compaction: first accepted lane always lands at tail, a second one at tail+1
  assign wr_a = acc0 ? '{waddr: bus.in0_waddr, wdata: bus.in0_wdata}
                     : '{waddr: bus.in1_waddr, wdata: bus.in1_wdata};
  assign wr_b = '{waddr: bus.in1_waddr, wdata: bus.in1_wdata};

`ifdef WB_COMMIT_FWD_EN
  commit_entry_t mem_all [DEPTH];
`endif

  wb_commit_mem #(
    .Depth (DEPTH),
    .PtrW  (PTR_W)
  ) u_mem (
    .clk_i     (clk),
    .rst_ni    (rst),
    .we_a_i    (push && (acc0 || acc1)),
    .waddr_a_i (tail_q),
    .wdata_a_i (wr_a),
    .we_b_i    (push && acc0 && acc1),
    .waddr_b_i (tail_nxt),
    .wdata_b_i (wr_b),
    .raddr_a_i (head_q),
    .raddr_b_i (head_nxt),
    .rdata_a_o (rd_a),
    .rdata_b_o (rd_b)
`ifdef WB_COMMIT_FWD_EN
    ,
    .mem_o     (mem_all)
`endif
  );

  always_comb begin
    n_push    = push ? ((PTR_W+1)'(acc0) + (PTR_W+1)'(acc1)) : '0;
    n_pop     = (PTR_W+1)'(we1) + (PTR_W+1)'(we2);
    head_d    = head_q + PTR_W'(n_pop);
    tail_d    = tail_q + PTR_W'(n_push);
    count_d   = count_q + n_push - n_pop;
    // A flushed cycle discards its inputs, so it cannot overflow either
    err_ovf_d = err_ovf_q | ((acc0 | acc1) & ~in_ready & ~bus.flush);
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      err_ovf_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.we1      = we1;
  assign bus.waddr1   = has1 ? rd_a.waddr : `NOPRegAddr;
  assign bus.wdata1   = has1 ? rd_a.wdata : `ZeroWord;
  assign bus.we2      = we2;
  assign bus.waddr2   = has2 ? rd_b.waddr : `NOPRegAddr;
  assign bus.wdata2   = has2 ? rd_b.wdata : `ZeroWord;
  assign bus.count    = count_q;
  assign bus.err_ovf  = err_ovf_q;

`ifdef WB_COMMIT_FWD_EN
  logic [`RegAddrBus] fwd_raddr [4];
  logic               fwd_hit   [4];
  logic [`RegBus]     fwd_data  [4];
  logic [PTR_W-1:0]   fwd_slot;

  assign fwd_raddr[0] = bus.fwd_raddr1;
  assign fwd_raddr[1] = bus.fwd_raddr2;
  assign fwd_raddr[2] = bus.fwd_raddr3;
  assign fwd_raddr[3] = bus.fwd_raddr4;

  // Walk oldest to youngest so the last match wins
  always_comb begin
    fwd_slot = '0;
    for (int k = 0; k < 4; k++) begin
      fwd_hit[k]  = 1'b0;
      fwd_data[k] = `ZeroWord;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fwd_slot = head_q + PTR_W'(i);
        if (((PTR_W+1)'(i) < count_q) && (fwd_raddr[k] != `NOPRegAddr) &&
            (mem_all[fwd_slot].waddr == fwd_raddr[k])) begin
          fwd_hit[k]  = 1'b1;
          fwd_data[k] = mem_all[fwd_slot].wdata;
        end
      end
    end
  end

  assign bus.fwd_hit1  = fwd_hit[0];
  assign bus.fwd_hit2  = fwd_hit[1];
  assign bus.fwd_hit3  = fwd_hit[2];
  assign bus.fwd_hit4  = fwd_hit[3];
  assign bus.fwd_data1 = fwd_data[0];
  assign bus.fwd_data2 = fwd_data[1];
  assign bus.fwd_data3 = fwd_data[2];
  assign bus.fwd_data4 = fwd_data[3];
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed bench for wb_commit_queue with an in-order scoreboard of expected regfile writes.
// Build with WB_COMMIT_FWD_EN defined to also exercise the forwarding ports.
module tb_wb_commit_queue;

  localparam int unsigned Depth = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_commit_queue_if #(.PTR_W(3)) bus ();

  wb_commit_queue #(
    .DEPTH (Depth),
    .PTR_W (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        sbq [$];
  logic [31:0] rf  [32];
  logic        ovf_m;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    bus.in0_valid = v0;
    bus.in0_waddr = a0;
    bus.in0_wdata = d0;
    bus.in1_valid = v1;
    bus.in1_waddr = a1;
    bus.in1_wdata = d1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // One clock: check the drain against the scoreboard, then update it for this edge
  task automatic tick();
    int   n;
    logic rdy, ew1, ew2;
    @(negedge clk);
    n   = sbq.size();
    rdy = (n <= int'(Depth) - 2);
    ew1 = (n >= 1) && !bus.stall && !bus.flush;
    ew2 = (n >= 2) && !bus.stall && !bus.flush;
    chk("count", 64'(bus.count), 64'(n));
    chk("in_ready", 64'(bus.in_ready), 64'(rdy));
    chk("err_ovf", 64'(bus.err_ovf), 64'(ovf_m));
    chk("we1", 64'(bus.we1), 64'(ew1));
    chk("we2", 64'(bus.we2), 64'(ew2));
    if (ew1) chk("port1", 64'({bus.waddr1, bus.wdata1}), 64'({sbq[0].a, sbq[0].d}));
    if (ew2) chk("port2", 64'({bus.waddr2, bus.wdata2}), 64'({sbq[1].a, sbq[1].d}));
    if (n == 1) chk("port2_idle", 64'({bus.waddr2, bus.wdata2}), 64'(0));
    if (bus.we1) rf[bus.waddr1] = bus.wdata1;
    if (bus.we2) rf[bus.waddr2] = bus.wdata2;
    if (ew1) void'(sbq.pop_front());
    if (ew2) void'(sbq.pop_front());
    if (bus.flush) begin
      sbq.delete();
    end else begin
      if (bus.in0_valid && bus.in0_waddr != 5'd0) begin
        if (rdy) sbq.push_back('{a: bus.in0_waddr, d: bus.in0_wdata});
        else ovf_m = 1'b1;
      end
      if (bus.in1_valid && bus.in1_waddr != 5'd0) begin
        if (rdy) sbq.push_back('{a: bus.in1_waddr, d: bus.in1_wdata});
        else ovf_m = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    ovf_m  = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rst       = 1'b0;
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    idle();
`ifdef WB_COMMIT_FWD_EN
    bus.fwd_raddr1 = 5'd0;
    bus.fwd_raddr2 = 5'd0;
    bus.fwd_raddr3 = 5'd0;
    bus.fwd_raddr4 = 5'd0;
`endif
    #1;
    chk("rst_count", 64'(bus.count), 64'(0));
    chk("rst_we", 64'({bus.we1, bus.we2}), 64'(0));
    chk("rst_port1", 64'({bus.waddr1, bus.wdata1}), 64'(0));
    chk("rst_err", 64'(bus.err_ovf), 64'(0));
    chk("rst_ready", 64'(bus.in_ready), 64'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Pair enqueue drains the next cycle on both ports
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    tick();
    idle();
    chk("pair_we", 64'({bus.we1, bus.we2}), 64'(2'b11));
    chk("pair_p1", 64'({bus.waddr1, bus.wdata1}), 64'({5'd3, 32'h11}));
    chk("pair_p2", 64'({bus.waddr2, bus.wdata2}), 64'({5'd4, 32'h22}));
    tick();
    chk("pair_count_after", 64'(bus.count), 64'(0));

    // r0 in lane 0 is filtered; lone lane 1 lands at tail and drains on port 1
    drive(1'b1, 5'd0, 32'hFF, 1'b1, 5'd5, 32'h55);
    tick();
    idle();
    chk("nop_count", 64'(bus.count), 64'(1));
    chk("nop_p1", 64'({bus.we1, bus.waddr1, bus.wdata1}), 64'({1'b1, 5'd5, 32'h55}));
    chk("nop_p2", 64'({bus.we2, bus.waddr2, bus.wdata2}), 64'(0));
    tick();

    // Same-cycle WAW to r7: younger must win in the regfile
    drive(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
    tick();
    idle();
    chk("waw_p1", 64'({bus.waddr1, bus.wdata1}), 64'({5'd7, 32'hA}));
    chk("waw_p2", 64'({bus.waddr2, bus.wdata2}), 64'({5'd7, 32'hB}));
    tick();
    chk("waw_rf", 64'(rf[7]), 64'(32'hB));

    // Fill under stall across the pointer wrap, overflow, then drain
    bus.stall = 1'b1;
    drive(1'b1, 5'd10, 32'h100, 1'b0, 5'd0, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(11 + 2 * i), 32'(32'h200 + i), 1'b1, 5'(12 + 2 * i), 32'(32'h300 + i));
      tick();
    end
    chk("fill_count", 64'(bus.count), 64'(7));
    chk("fill_ready", 64'(bus.in_ready), 64'(0));
    drive(1'b1, 5'd20, 32'h999, 1'b1, 5'd21, 32'h998);
    tick();
    idle();
    chk("ovf_flag", 64'(bus.err_ovf), 64'(1));
    chk("ovf_count", 64'(bus.count), 64'(7));
    bus.stall = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("drain_count", 64'(bus.count), 64'(0));
    chk("drain_rf16", 64'(rf[16]), 64'(32'h302));
    chk("drop_rf20", 64'(rf[20]), 64'(0));
    chk("ovf_sticky", 64'(bus.err_ovf), 64'(1));

    // Flush at count 5 with a simultaneous push
    bus.stall = 1'b1;
    drive(1'b1, 5'd1, 32'h31, 1'b0, 5'd0, 32'h0);
    tick();
    drive(1'b1, 5'd2, 32'h32, 1'b1, 5'd3, 32'h33);
    tick();
    drive(1'b1, 5'd4, 32'h34, 1'b1, 5'd5, 32'h35);
    tick();
    chk("flush_pre_count", 64'(bus.count), 64'(5));
    bus.stall = 1'b0;
    bus.flush = 1'b1;
    drive(1'b1, 5'd6, 32'h36, 1'b1, 5'd8, 32'h38);
    #1;
    chk("flush_we", 64'({bus.we1, bus.we2}), 64'(0));
    tick();
    bus.flush = 1'b0;
    idle();
    chk("flush_count", 64'(bus.count), 64'(0));
    chk("flush_we_after", 64'({bus.we1, bus.we2}), 64'(0));
    tick();
    tick();

    // Async reset in the middle of a drain cycle
    drive(1'b1, 5'd24, 32'h77, 1'b1, 5'd25, 32'h78);
    tick();
    idle();
    chk("mid_we1", 64'(bus.we1), 64'(1));
    rst = 1'b0;
    #1;
    chk("arst_we", 64'({bus.we1, bus.we2}), 64'(0));
    chk("arst_count", 64'(bus.count), 64'(0));
    chk("arst_err", 64'(bus.err_ovf), 64'(0));
    sbq.delete();
    ovf_m = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_rf24", 64'(rf[24]), 64'(0));
    tick();

`ifdef WB_COMMIT_FWD_EN
    // Youngest match wins; r0 and absent registers never hit
    bus.stall = 1'b1;
    drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2);
    tick();
    idle();
    bus.fwd_raddr1 = 5'd9;
    bus.fwd_raddr2 = 5'd0;
    bus.fwd_raddr3 = 5'd30;
    bus.fwd_raddr4 = 5'd9;
    #1;
    chk("fwd_hit1", 64'({bus.fwd_hit1, bus.fwd_data1}), 64'({1'b1, 32'h2}));
    chk("fwd_hit2", 64'(bus.fwd_hit2), 64'(0));
    chk("fwd_hit3", 64'(bus.fwd_hit3), 64'(0));
    chk("fwd_hit4", 64'({bus.fwd_hit4, bus.fwd_data4}), 64'({1'b1, 32'h2}));
    bus.stall = 1'b0;
    #1;
    chk("fwd_pop_hit", 64'({bus.fwd_hit1, bus.fwd_data1}), 64'({1'b1, 32'h2}));
    tick();
    chk("fwd_empty", 64'(bus.fwd_hit1), 64'(0));
    chk("fwd_rf9", 64'(rf[9]), 64'(32'h2));
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
